// File: rtl/decode_ctrl_flow.sv
// ID-stage control-flow and hazard unit: resolves MIPS-I branches/jumps with one
// architectural delay slot, detects load-use / branch-operand hazards, registers ID/EX.
module decode_ctrl_flow #(
    parameter bit          DELAY_SLOT_TRAP = 1'b1,
    parameter int unsigned STALL_CNT_W     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            if_id_instruc,
    input  logic [31:0]            if_id_nextpc,
    input  logic [31:0]            rf_id_rs_data,
    input  logic [31:0]            rf_id_rt_data,
    input  logic [4:0]             ex_mem_writereg,
    input  logic                   ex_mem_memread,
    output logic [4:0]             id_rf_rs_addr,
    output logic [4:0]             id_rf_rt_addr,
    output logic                   id_stall,
    output logic                   id_if_selpcsource,
    output logic [1:0]             id_if_selpctype,
    output logic [31:0]            id_if_pcimd2ext,
    output logic [31:0]            id_if_rega,
    output logic [31:0]            id_if_pcindex,
    output logic [31:0]            id_ex_instruc,
    output logic [31:0]            id_ex_nextpc,
    output logic [31:0]            id_ex_rega,
    output logic [31:0]            id_ex_regb,
    output logic [4:0]             id_ex_writereg,
    output logic                   id_ex_regwrite,
    output logic                   id_ex_memread,
    output logic                   id_ex_memwrite,
    output logic                   id_ex_link,
    output logic [STALL_CNT_W-1:0] id_stall_count
);
    typedef enum logic {NORMAL = 1'b0, DSLOT = 1'b1} state_t;
    state_t state;

    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    assign op = if_id_instruc[31:26];
    assign fn = if_id_instruc[5:0];
    assign rs = if_id_instruc[25:21];
    assign rt = if_id_instruc[20:16];
    assign rd = if_id_instruc[15:11];
    assign id_rf_rs_addr = rs;
    assign id_rf_rt_addr = rt;

    logic is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
    logic is_rtype, is_alui, is_load, is_store, is_resv;
    always_comb begin
        is_beq   = (op == 6'h04);
        is_bne   = (op == 6'h05);
        is_j     = (op == 6'h02);
        is_jal   = (op == 6'h03);
        is_jr    = (op == 6'h00) && (fn == 6'h08);
        is_jalr  = (op == 6'h00) && (fn == 6'h09);
        is_rtype = (op == 6'h00) && !is_jr && !is_jalr;
        is_alui  = (op[5:3] == 3'b001);
        is_load  = (op >= 6'h20) && (op <= 6'h25);
        is_store = (op >= 6'h28) && (op <= 6'h2B);
        is_resv  = !(is_beq || is_bne || is_j || is_jal || (op == 6'h00) ||
                     is_alui || is_load || is_store);
    end

    function automatic logic src_hit(input logic used, input logic [4:0] src,
                                     input logic [4:0] dst);
        return used && (src != 5'd0) && (src == dst);
    endfunction

    logic use_rs, use_rt, br_rs, br_rt, load_use, br_haz, hazard;
    assign use_rs = is_rtype || is_jr || is_jalr || is_alui || is_load || is_store ||
                    is_beq || is_bne;
    assign use_rt = is_rtype || is_store || is_beq || is_bne;
    assign br_rs  = is_beq || is_bne || is_jr || is_jalr;
    assign br_rt  = is_beq || is_bne;

    assign load_use = id_ex_memread &&
                      (src_hit(use_rs, rs, id_ex_writereg) || src_hit(use_rt, rt, id_ex_writereg));
    assign br_haz   = (id_ex_regwrite &&
                       (src_hit(br_rs, rs, id_ex_writereg) || src_hit(br_rt, rt, id_ex_writereg))) ||
                      (ex_mem_memread &&
                       (src_hit(br_rs, rs, ex_mem_writereg) || src_hit(br_rt, rt, ex_mem_writereg)));
    assign hazard   = load_use || br_haz;

    logic cf, dslot_cf, taken, want_redir, bubble;
    assign cf         = is_beq || is_bne || is_j || is_jal || is_jr || is_jalr;
    assign dslot_cf   = (state == DSLOT) && cf;
    assign taken      = (is_beq && (rf_id_rs_data == rf_id_rt_data)) ||
                        (is_bne && (rf_id_rs_data != rf_id_rt_data));
    // Control flow in the delay slot never redirects normally; it traps or dies as a bubble.
    assign want_redir = is_resv || (dslot_cf && DELAY_SLOT_TRAP) ||
                        ((state == NORMAL) && (taken || is_j || is_jal || is_jr || is_jalr));
    assign bubble     = hazard || is_resv || dslot_cf;

    assign id_stall          = reset && hazard;
    assign id_if_selpcsource = reset && !hazard && want_redir;
    assign id_if_pcimd2ext   = if_id_nextpc + {{14{if_id_instruc[15]}}, if_id_instruc[15:0], 2'b00};
    assign id_if_rega        = rf_id_rs_data;
    assign id_if_pcindex     = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

    always_comb begin
        id_if_selpctype = 2'b00;
        if (is_resv || dslot_cf)   id_if_selpctype = 2'b11;
        else if (is_j || is_jal)   id_if_selpctype = 2'b10;
        else if (is_jr || is_jalr) id_if_selpctype = 2'b01;
    end

    logic [4:0] dest;
    always_comb begin
        dest = 5'd0;
        if (is_rtype || is_jalr)     dest = rd;
        else if (is_alui || is_load) dest = rt;
        else if (is_jal)             dest = 5'd31;
    end

    // Link value is taken from the jump's own nextpc, never from the delay-slot instruction.
    logic link;
    assign link = is_jal || is_jalr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= NORMAL;
            id_stall_count <= '0;
            id_ex_instruc  <= '0;
            id_ex_nextpc   <= '0;
            id_ex_rega     <= '0;
            id_ex_regb     <= '0;
            id_ex_writereg <= '0;
            id_ex_regwrite <= 1'b0;
            id_ex_memread  <= 1'b0;
            id_ex_memwrite <= 1'b0;
            id_ex_link     <= 1'b0;
        end else begin
            if (hazard && !(&id_stall_count))
                id_stall_count <= id_stall_count + STALL_CNT_W'(1);
            if (!hazard)
                state <= ((state == NORMAL) && id_if_selpcsource && (id_if_selpctype != 2'b11))
                         ? DSLOT : NORMAL;
            if (bubble) begin
                id_ex_instruc  <= '0;
                id_ex_nextpc   <= '0;
                id_ex_rega     <= '0;
                id_ex_regb     <= '0;
                id_ex_writereg <= '0;
                id_ex_regwrite <= 1'b0;
                id_ex_memread  <= 1'b0;
                id_ex_memwrite <= 1'b0;
                id_ex_link     <= 1'b0;
            end else begin
                id_ex_instruc  <= if_id_instruc;
                id_ex_nextpc   <= if_id_nextpc;
                id_ex_rega     <= rf_id_rs_data;
                id_ex_regb     <= link ? (if_id_nextpc + 32'd4) : rf_id_rt_data;
                id_ex_writereg <= dest;
                id_ex_regwrite <= (dest != 5'd0);
                id_ex_memread  <= is_load;
                id_ex_memwrite <= is_store;
                id_ex_link     <= link;
            end
        end
    end
endmodule

// File: tb/tb_decode_ctrl_flow.sv
// Scoreboard bench: two DUTs (delay-slot trap on / off) against an instruction-class reference model.
module tb_decode_ctrl_flow;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruc = '0, nextpc = '0, rs_data = '0, rt_data = '0;
    logic [4:0]  em_wr = '0;
    logic        em_rd = 1'b0;
    always #5 clock = ~clock;

    logic [4:0]  rsa [2], rta [2], wr [2];
    logic        stall [2], src [2], rw [2], mr [2], mw [2], lk [2];
    logic [1:0]  typ [2];
    logic [31:0] imd [2], idx [2], rega [2], xins [2], xnpc [2], xra [2], xrb [2];
    logic [15:0] cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_ctrl_flow #(.DELAY_SLOT_TRAP(g == 0), .STALL_CNT_W(16)) u_dut (
            .clock(clock), .reset(reset), .if_id_instruc(instruc), .if_id_nextpc(nextpc),
            .rf_id_rs_data(rs_data), .rf_id_rt_data(rt_data),
            .ex_mem_writereg(em_wr), .ex_mem_memread(em_rd),
            .id_rf_rs_addr(rsa[g]), .id_rf_rt_addr(rta[g]), .id_stall(stall[g]),
            .id_if_selpcsource(src[g]), .id_if_selpctype(typ[g]), .id_if_pcimd2ext(imd[g]),
            .id_if_rega(rega[g]), .id_if_pcindex(idx[g]),
            .id_ex_instruc(xins[g]), .id_ex_nextpc(xnpc[g]), .id_ex_rega(xra[g]),
            .id_ex_regb(xrb[g]), .id_ex_writereg(wr[g]), .id_ex_regwrite(rw[g]),
            .id_ex_memread(mr[g]), .id_ex_memwrite(mw[g]), .id_ex_link(lk[g]),
            .id_stall_count(cnt[g]));
    end

    typedef struct packed {
        logic rst_n; logic adv; logic [31:0] ins, npc, rsd, rtd; logic [4:0] emw; logic emr;
    } stim_t;
    typedef struct packed {
        logic stall, src; logic [1:0] typ; logic [31:0] imd, idx, rega; logic [4:0] rsa, rta;
    } comb_t;
    typedef struct packed {
        logic [31:0] ins, npc, ra, rb; logic [4:0] wr; logic rw, mr, mw, lk; logic [15:0] cnt;
    } idex_t;
    typedef struct packed { comb_t c; idex_t ix; } exp_t;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BEQ = 4, K_BNE = 5,
                   K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9, K_RSV = 10;

    int    checks = 0, errors = 0;
    exp_t  q0[$], q1[$];
    logic  m_dslot [2];
    idex_t m_idex [2];
    stim_t stq[$];

    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        int o = int'(op);
        if (o == 0) return (fn == 6'h08) ? K_JR : (fn == 6'h09) ? K_JALR : K_R;
        if (o == 2) return K_J;
        if (o == 3) return K_JAL;
        if (o == 4) return K_BEQ;
        if (o == 5) return K_BNE;
        if (o >= 8 && o <= 15) return K_I;
        if (o >= 32 && o <= 37) return K_LD;
        if (o >= 40 && o <= 43) return K_ST;
        return K_RSV;
    endfunction

    // Reference: architectural rules per instruction class; updates the model's slot/ID-EX state.
    task automatic model(input bit trap, input stim_t s, inout logic dslot, inout idex_t ix,
                         output exp_t e, output logic stl);
        logic [4:0] rs, rt, rd, dst;
        logic urs, urt, brs, brt, haz, cf, redir, bub;
        logic [1:0] t;
        int k;
        idex_t nx;
        rs = s.ins[25:21]; rt = s.ins[20:16]; rd = s.ins[15:11];
        k = kind(s.ins[31:26], s.ins[5:0]);
        urs = k inside {K_R, K_JR, K_JALR, K_I, K_LD, K_ST, K_BEQ, K_BNE};
        urt = k inside {K_R, K_ST, K_BEQ, K_BNE};
        brs = k inside {K_BEQ, K_BNE, K_JR, K_JALR};
        brt = k inside {K_BEQ, K_BNE};
        cf  = k inside {K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR};
        haz = 1'b0;
        if (ix.mr && ix.wr != 0 && ((urs && rs == ix.wr) || (urt && rt == ix.wr))) haz = 1'b1;
        if (ix.rw && ix.wr != 0 && ((brs && rs == ix.wr) || (brt && rt == ix.wr))) haz = 1'b1;
        if (s.emr && s.emw != 0 && ((brs && rs == s.emw) || (brt && rt == s.emw))) haz = 1'b1;
        t = 2'd0; redir = 1'b0;
        if (k == K_RSV || (dslot && cf)) begin
            t = 2'd3; redir = (k == K_RSV) || trap;
        end else if (!dslot) begin
            if (k == K_BEQ) redir = (s.rsd == s.rtd);
            if (k == K_BNE) redir = (s.rsd != s.rtd);
            if (k == K_J || k == K_JAL) begin t = 2'd2; redir = 1'b1; end
            if (k == K_JR || k == K_JALR) begin t = 2'd1; redir = 1'b1; end
        end
        if (haz) redir = 1'b0;
        e.c.stall = s.rst_n && haz;
        e.c.src   = s.rst_n && redir;
        e.c.typ   = e.c.src ? t : 2'd0;
        e.c.imd   = s.npc + 32'(int'($signed(s.ins[15:0])) * 4);
        e.c.idx   = {s.npc[31:28], s.ins[25:0], 2'b00};
        e.c.rega  = s.rsd;
        e.c.rsa   = rs;
        e.c.rta   = rt;
        if (!s.rst_n) begin
            dslot = 1'b0; ix = '0; e.ix = '0; stl = 1'b0;
            return;
        end
        e.ix = ix;
        stl  = haz;
        dst = (k == K_R || k == K_JALR) ? rd : (k == K_I || k == K_LD) ? rt :
              (k == K_JAL) ? 5'd31 : 5'd0;
        bub = haz || k == K_RSV || (dslot && cf);
        nx = '0;
        if (!bub) begin
            nx.ins = s.ins; nx.npc = s.npc; nx.ra = s.rsd;
            nx.lk  = (k == K_JAL || k == K_JALR);
            nx.rb  = nx.lk ? s.npc + 32'd4 : s.rtd;
            nx.wr  = dst; nx.rw = (dst != 0); nx.mr = (k == K_LD); nx.mw = (k == K_ST);
        end
        nx.cnt = (haz && ix.cnt != 16'hFFFF) ? 16'(ix.cnt + 16'd1) : ix.cnt;
        if (!haz) dslot = !dslot && redir && t != 2'd3;
        ix = nx;
    endtask

    function automatic stim_t mk(input logic rst_n, input logic adv, input logic [31:0] ins,
                                 input logic [31:0] npc, input logic [31:0] rsd,
                                 input logic [31:0] rtd);
        stim_t s;
        s.rst_n = rst_n; s.adv = adv; s.ins = ins; s.npc = npc; s.rsd = rsd; s.rtd = rtd;
        s.emw = 5'd0; s.emr = 1'b0;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        logic [5:0] op, fn;
        int sel;
        op = 6'h00; fn = 6'($urandom);
        sel = $urandom_range(0, 10);
        case (sel)
            0: fn = 6'($urandom_range(0, 63));
            1: op = 6'($urandom_range(8, 15));
            2: op = 6'($urandom_range(32, 37));
            3: op = 6'($urandom_range(40, 43));
            4: op = 6'h04;
            5: op = 6'h05;
            6: op = 6'h02;
            7: op = 6'h03;
            8: fn = 6'h08;
            9: fn = 6'h09;
            default: case ($urandom_range(0, 5))
                0: op = 6'h01; 1: op = 6'h06; 2: op = 6'h07;
                3: op = 6'h10; 4: op = 6'h26; default: op = 6'h3F;
            endcase
        endcase
        s.ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom), fn};
        s.npc   = $urandom & 32'hFFFF_FFFC;
        s.rsd   = 32'($urandom_range(0, 3));
        s.rtd   = 32'($urandom_range(0, 3));
        s.emw   = 5'($urandom_range(0, 7));
        s.emr   = ($urandom_range(0, 3) == 0);
        s.rst_n = ($urandom_range(0, 49) != 0);
        s.adv   = 1'b0;
        return s;
    endfunction

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t got %h exp %h", name, $time, got, exp);
        end
    endtask

    // Monitor: one expectation per cycle per DUT, compared mid-cycle.
    initial begin
        exp_t e;
        comb_t gc;
        idex_t gx;
        forever begin
            @(negedge clock);
            for (int g = 0; g < 2; g++) begin
                if ((g == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
                    e = (g == 0) ? q0.pop_front() : q1.pop_front();
                    gc = '{stall[g], src[g], src[g] ? typ[g] : 2'd0, imd[g], idx[g], rega[g],
                           rsa[g], rta[g]};
                    gx = '{xins[g], xnpc[g], xra[g], xrb[g], wr[g], rw[g], mr[g], mw[g], lk[g],
                           cnt[g]};
                    check($sformatf("dut%0d id_if/stall", g), 160'(gc), 160'(e.c));
                    check($sformatf("dut%0d id_ex/count", g), 160'(gx), 160'(e.ix));
                end
            end
        end
    end

    initial begin
        stim_t s;
        exp_t e0, e1;
        logic st0, st1;
        int i, cyc;
        m_dslot[0] = 1'b0; m_dslot[1] = 1'b0; m_idex[0] = '0; m_idex[1] = '0;
        stq.push_back(mk(0, 0, 32'h0000_0000, 32'h1000, 0, 0));
        stq.push_back(mk(1, 0, 32'h0000_0000, 32'h1000, 0, 0));
        stq.push_back(mk(1, 0, 32'h1022_0003, 32'h0104, 5, 5));          // BEQ r1,r2,+3 taken
        stq.push_back(mk(1, 0, 32'h00E8_3020, 32'h0110, 1, 2));          // ADD in delay slot
        stq.push_back(mk(1, 0, 32'h8C23_0000, 32'h0114, 7, 0));          // LW r3
        stq.push_back(mk(1, 0, 32'h0061_2020, 32'h0118, 9, 7));          // ADD r4,r3,r1
        stq.push_back(mk(1, 0, 32'h03E0_0008, 32'h011C, 32'h200, 0));    // JR r31
        stq.push_back(mk(1, 0, 32'h0000_0000, 32'h0204, 0, 0));
        stq.push_back(mk(1, 0, 32'h0C00_0040, 32'h8000_0010, 0, 0));     // JAL 0x40
        stq.push_back(mk(1, 0, 32'h1422_0001, 32'h8000_0104, 1, 2));     // BNE in delay slot
        stq.push_back(mk(1, 0, 32'hFC00_0000, 32'h0300, 0, 0));          // reserved 0x3F
        stq.push_back(mk(1, 0, 32'h2005_0001, 32'h0304, 0, 0));          // ADDI r5,r0,1
        stq.push_back(mk(1, 0, 32'h10A0_0002, 32'h0308, 0, 0));          // BEQ r5,r0 hazard
        stq.push_back(mk(1, 0, 32'h0000_0000, 32'h0310, 0, 0));
        stq.push_back(mk(1, 0, 32'h8C23_0000, 32'h0400, 0, 0));
        stq.push_back(mk(1, 1, 32'h0061_2020, 32'h0404, 0, 0));          // stalls, then reset
        stq.push_back(mk(0, 0, 32'h0061_2020, 32'h0404, 0, 0));
        stq.push_back(mk(0, 0, 32'h0000_0000, 32'h0404, 0, 0));
        stq.push_back(mk(1, 0, 32'h0000_0000, 32'h0404, 0, 0));
        for (int n = 0; n < 400; n++) stq.push_back(rnd());

        repeat (2) @(posedge clock);
        i = 0; cyc = 0;
        while (i < stq.size()) begin
            @(posedge clock); #1;
            s = stq[i];
            reset = s.rst_n; instruc = s.ins; nextpc = s.npc; rs_data = s.rsd; rt_data = s.rtd;
            em_wr = s.emw; em_rd = s.emr;
            model(1'b1, s, m_dslot[0], m_idex[0], e0, st0);
            model(1'b0, s, m_dslot[1], m_idex[1], e1, st1);
            q0.push_back(e0);
            q1.push_back(e1);
            // A held IF/ID sees the EX/MEM load move on next cycle.
            if (!st0 || s.adv) i++;
            else stq[i].emr = 1'b0;
            cyc++;
            if (cyc > 5000) begin
                checks++; errors++;
                $display("FAIL cycle budget exceeded at stimulus %0d", i);
                break;
            end
        end
        @(negedge clock); @(negedge clock);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain got %0d/%0d left exp 0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
